inst_fetch_unit: RTL and testbench

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

---
 rtl/inst_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// inst_fetch_unit
//
// Purpose
//   Instruction fetch front end. It issues one instruction-memory request at
//   a time, places each returned word with its address in a small fetch
//   buffer, and presents the buffer head to the decode stage. A Branch_Flush
//   empties the buffer and may redirect the fetch PC. A request that is still
//   outstanding when the flush arrives is allowed to complete in DRAIN, and
//   its returned data is dropped.
//
// Configuration
//   IFU_PREFETCH_EN  defined   : two-entry fetch buffer. A new request may be
//                                issued while one entry is still held.
//                    undefined : one-entry fetch buffer. A request is issued
//                                only when the buffer is empty or its head is
//                                being consumed in the same cycle.
//
// Parameters
//   RESET_PC       first fetch address after reset
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   Inst_Req       decode is ready to take the head instruction
//   Branch_Flush   flush buffer / redirect
//   PCsrcSel       3'b001 selects Branch_Target on flush, otherwise PC kept
//   Branch_Target  redirect address (low two bits ignored)
//   IMem_Req       memory request valid (high exactly in REQ)
//   IMem_Addr      word-aligned fetch address
//   IMem_Ack       memory returns IMem_Data for the outstanding request
//   IMem_Data      returned instruction word
//   Inst_Ready     buffer head valid
//   Fetch_Inst     head instruction
//   Fetch_PC       head instruction address
// ============================================================================
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Inst_Req,
    input  logic        Branch_Flush,
    input  logic [2:0]  PCsrcSel,
    input  logic [31:0] Branch_Target,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic        Inst_Ready,
    output logic [31:0] Fetch_Inst,
    output logic [31:0] Fetch_PC
);

`ifdef IFU_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_L = 2'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;

    // Fetch buffer: entry 0 is always the head; entries shift down on consume.
    logic [31:0] fb_pc   [DEPTH];
    logic [31:0] fb_inst [DEPTH];
    logic [1:0]  count;

    logic        consume;
    logic        write;
    logic        redirect;
    logic        room;
    logic [1:0]  count_next;
    logic [31:0] wr_idx;
    logic [31:0] target_aligned;

    always_comb begin
        consume        = (count != 2'd0) & Inst_Req & ~Branch_Flush;
        write          = (state == REQ) & IMem_Ack & ~Branch_Flush;
        redirect       = Branch_Flush & (PCsrcSel == 3'b001);
        target_aligned = Branch_Target & 32'hFFFF_FFFC;
        count_next     = count + {1'b0, write} - {1'b0, consume};
        // A write in the same cycle as a consume lands one slot lower,
        // because the head is shifted out at the same edge.
        wr_idx         = 32'(count) - 32'(consume);
        // Room counts a slot that is freed by a consume on this same edge.
        room           = (count < DEPTH_L) | consume;
    end

    // Control FSM. IMem_Req is registered and is updated together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            IMem_Req <= 1'b0;
            pc       <= RESET_PC;
        end else begin
            if (redirect) begin
                pc <= target_aligned;
            end else if (write) begin
                pc <= pc + 32'd4;
            end

            case (state)
                IDLE: begin
                    if (!Branch_Flush && room) begin
                        state    <= REQ;
                        IMem_Req <= 1'b1;
                    end
                end
                REQ: begin
                    if (IMem_Ack) begin
                        // An ack that coincides with a flush is dropped and
                        // the FSM returns to IDLE.
                        if (!Branch_Flush && (count_next < DEPTH_L)) begin
                            state    <= REQ;
                            IMem_Req <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            IMem_Req <= 1'b0;
                        end
                    end else if (Branch_Flush) begin
                        state    <= DRAIN;
                        IMem_Req <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (IMem_Ack) begin
                        state <= IDLE;
                    end
                    IMem_Req <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    IMem_Req <= 1'b0;
                end
            endcase
        end
    end

    // Fetch buffer storage and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fb_pc[i]   <= '0;
                fb_inst[i] <= '0;
            end
        end else if (Branch_Flush) begin
            count <= 2'd0;
        end else begin
            count <= count_next;
            if (consume) begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    fb_pc[i]   <= fb_pc[i + 1];
                    fb_inst[i] <= fb_inst[i + 1];
                end
            end
            // This comes after the shift so that the new entry wins when both
            // target the same slot.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (write && (i == wr_idx)) begin
                    fb_pc[i]   <= pc;
                    fb_inst[i] <= IMem_Data;
                end
            end
        end
    end

    assign IMem_Addr  = pc;
    assign Inst_Ready = (count != 2'd0);
    assign Fetch_Inst = fb_inst[0];
    assign Fetch_PC   = fb_pc[0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

`ifdef IFU_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        Inst_Req, Branch_Flush, IMem_Ack;
    logic [2:0]  PCsrcSel;
    logic [31:0] Branch_Target, IMem_Data;
    logic        IMem_Req, Inst_Ready;
    logic [31:0] IMem_Addr, Fetch_Inst, Fetch_PC;

    logic        hi_req, hi_ready, hi_ack;
    logic [31:0] hi_addr, hi_inst, hi_pc, hi_data;

    inst_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .Inst_Req(Inst_Req), .Branch_Flush(Branch_Flush),
        .PCsrcSel(PCsrcSel), .Branch_Target(Branch_Target), .IMem_Req(IMem_Req),
        .IMem_Addr(IMem_Addr), .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data),
        .Inst_Ready(Inst_Ready), .Fetch_Inst(Fetch_Inst), .Fetch_PC(Fetch_PC)
    );

    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .clk(clk), .rst_n(rst_n), .Inst_Req(1'b1), .Branch_Flush(1'b0),
        .PCsrcSel(3'b000), .Branch_Target(32'h0), .IMem_Req(hi_req),
        .IMem_Addr(hi_addr), .IMem_Ack(hi_ack), .IMem_Data(hi_data),
        .Inst_Ready(hi_ready), .Fetch_Inst(hi_inst), .Fetch_PC(hi_pc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: {pc, inst} pushed when memory returns an accepted word.
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    bit          outstanding;
    int          wait_cnt;
    logic [31:0] out_addr;

    bit          ctl_req, ctl_flush, fl_on_ack, hold;
    logic [2:0]  ctl_sel;
    logic [31:0] ctl_tgt;
    int          lat;
    int          hi_n;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One clock: sample at the falling edge, update the model, drive the inputs.
    task automatic tick();
        bit          ack, fl, cons;
        logic [31:0] data;
        logic [63:0] e;
        @(negedge clk);
        ack  = 1'b0;
        data = '0;
        check_eq("ready", 32'(Inst_Ready), 32'(exp_q.size() != 0));

        if (IMem_Req && !outstanding) begin
            outstanding = 1'b1;
            wait_cnt    = 0;
            out_addr    = IMem_Addr;
        end
        if (outstanding) begin
            if (!hold && wait_cnt >= lat) begin
                ack         = 1'b1;
                data        = mem_word(out_addr);
                outstanding = 1'b0;
            end else begin
                wait_cnt++;
            end
        end

        fl = ctl_flush | (ack & fl_on_ack & IMem_Req);
        if (ack && fl_on_ack && IMem_Req) fl_on_ack = 1'b0;

        if (ack && IMem_Req) begin
            check_eq("addr", IMem_Addr, exp_pc);
            if (!fl) begin
                exp_q.push_back({IMem_Addr, data});
                exp_pc += 32'd4;
            end
        end

        cons = ctl_req && Inst_Ready && !fl;
        if (cons) begin
            if (exp_q.size() == 0) begin
                check_eq("pop_empty", 32'(Inst_Ready), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("fetch_pc", Fetch_PC, e[63:32]);
                check_eq("fetch_inst", Fetch_Inst, e[31:0]);
            end
        end

        if (fl) begin
            exp_q.delete();
            if (ctl_sel == 3'b001) exp_pc = ctl_tgt & 32'hFFFF_FFFC;
        end

        Inst_Req      = ctl_req;
        Branch_Flush  = fl;
        PCsrcSel      = ctl_sel;
        Branch_Target = ctl_tgt;
        IMem_Ack      = ack;
        IMem_Data     = data;
        ctl_flush     = 1'b0;

        if (hi_req && hi_n < 2) begin
            check_eq("hi_addr", hi_addr, (hi_n == 0) ? 32'hFFFF_FFFC : 32'h0000_0000);
            hi_n++;
        end
        hi_ack  = hi_req;
        hi_data = ~hi_addr;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && !IMem_Req; i++) tick();
        check_eq("wait_req", 32'(IMem_Req), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        Inst_Req = 1'b0; Branch_Flush = 1'b0; PCsrcSel = 3'b000; Branch_Target = '0;
        IMem_Ack = 1'b0; IMem_Data = '0; hi_ack = 1'b0; hi_data = '0;
        ctl_req = 1'b0; ctl_flush = 1'b0; fl_on_ack = 1'b0; hold = 1'b0;
        ctl_sel = 3'b000; ctl_tgt = '0; lat = 0; hi_n = 0;
        outstanding = 1'b0; wait_cnt = 0; out_addr = '0; exp_pc = 32'h0;

        // Reset values, sampled before any clock edge
        #1;
        check_eq("rst_req", 32'(IMem_Req), 32'd0);
        check_eq("rst_ready", 32'(Inst_Ready), 32'd0);
        check_eq("rst_inst", Fetch_Inst, 32'd0);
        check_eq("rst_pc", Fetch_PC, 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Streaming fetch, single-cycle memory, decode always ready
        ctl_req = 1'b1; lat = 0;
        repeat (12) tick();

        // Decode stall: buffer fills, request stops, nothing lost on resume
        ctl_req = 1'b0;
        repeat (10) tick();
        check_eq("stall_req", 32'(IMem_Req), 32'd0);
        check_eq("fill", 32'(exp_q.size()), 32'(DEPTH));
        ctl_req = 1'b1;
        repeat (8) tick();

        // Flush while REQ is waiting, followed by further flushes in DRAIN
        hold = 1'b1;
        wait_req();
        ctl_flush = 1'b1; ctl_sel = 3'b001; ctl_tgt = 32'h0000_0303;
        tick();
        tick();
        check_eq("drain_req", 32'(IMem_Req), 32'd0);
        ctl_flush = 1'b1; ctl_sel = 3'b001; ctl_tgt = 32'h0000_0103;
        tick();
        ctl_flush = 1'b1; ctl_sel = 3'b100; ctl_tgt = 32'h0000_0555;
        tick();
        check_eq("drain_hold", 32'(IMem_Req), 32'd0);
        hold = 1'b0;
        repeat (8) tick();

        // Flush coincident with ack
        lat = 1; fl_on_ack = 1'b1; ctl_sel = 3'b001; ctl_tgt = 32'h0000_0200;
        for (int i = 0; i < 30 && fl_on_ack; i++) tick();
        check_eq("flush_ack_seen", 32'(fl_on_ack), 32'd0);
        tick();
        check_eq("ready_after_flush", 32'(Inst_Ready), 32'd0);
        ctl_sel = 3'b000;
        repeat (6) tick();

        // Random traffic with occasional flushes
        for (int n = 0; n < 300; n++) begin
            ctl_req = ($urandom_range(0, 3) != 0);
            lat     = $urandom_range(0, 2);
            if ($urandom_range(0, 19) == 0) begin
                ctl_flush = 1'b1;
                ctl_sel   = 3'($urandom_range(0, 7));
                ctl_tgt   = $urandom;
            end
            tick();
        end
        ctl_req = 1'b1; lat = 0;
        repeat (8) tick();

        // Reset in the middle of a request, then a stale ack right after release
        hold = 1'b1;
        wait_req();
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(IMem_Req), 32'd0);
        check_eq("mid_rst_ready", 32'(Inst_Ready), 32'd0);
        check_eq("mid_rst_pc", Fetch_PC, 32'd0);
        check_eq("mid_rst_inst", Fetch_Inst, 32'd0);
        exp_q.delete();
        outstanding = 1'b0; exp_pc = 32'h0; hold = 1'b0; lat = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        IMem_Ack  = 1'b1;
        IMem_Data = 32'hDEAD_BEEF;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
